alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Parametrised, multi-cycle successor to the CR16 single-cycle ALU control decode. It accepts one operation per valid/ready handshake and runs single-cycle arithmetic/logic ops directly. Shifts run one bit per cycle and, when compiled in, multiply runs as a shift-add sequence. Result, CR16 PSR flags and an error strobe are presented behind a valid/ready output handshake. It sits between the CR16 decode stage and the register-file writeback.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits; power of two, 8..64
- SHW, $clog2(WIDTH), derived; shift amount field is b[SHW:0], two's complement

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept; high only in IDLE
- op  in  4  operation code (package constants)
- a  in  WIDTH  operand A (destination/shifted value)
- b  in  WIDTH  operand B (source/shift amount)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flags  out  5  {C,L,F,Z,N}, registered PSR flags
- err  out  1  illegal op; valid with out_valid

## Operation
- Op codes: ADD=0, SUB=1 (a-b), CMP=2, AND=3, OR=4, XOR=5, MOV=6 (result=b), LSH=7, ASH=8, MUL=9; 10..15 illegal.
- FSM states IDLE, SHIFT, MUL, DONE.
  - IDLE: in_ready=1. On in_valid, capture the operands.
    - Single-cycle and illegal ops go to DONE.
    - LSH/ASH with nonzero amount go to SHIFT; amount 0 goes to DONE with result=a.
    - MUL goes to MUL.
  - SHIFT: k = signed b[SHW:0], so |k| ranges 1..WIDTH. Each cycle shifts the working register one bit and decrements the counter, then goes to DONE when the counter is 0.
    - Positive k shifts left with zero fill.
    - Negative k shifts right: zero fill for LSH, sign fill for ASH.
  - MUL: unsigned shift-add for exactly WIDTH cycles. result = low WIDTH bits of a*b. Then goes to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Flags:
  - ADD: C=carry out, F=signed overflow; Z,N,L unchanged.
  - SUB: C=borrow (a<b unsigned), F=signed overflow.
  - CMP: Z=(a==b), N=(a<b signed), L=(a<b unsigned); result=a; C,F unchanged.
  - All other ops leave flags unchanged.
  - Flags update in the cycle the op enters DONE.
- Illegal op: result=0, err=1, flags unchanged. err clears when the result is accepted.
- Width rules: all arithmetic is modulo 2^WIDTH. Carry uses a WIDTH+1-bit sum.

## Timing
- Reset values: in_ready=0 while reset is asserted, then 1 (IDLE); out_valid=0, result=0, flags=0, err=0, FSM=IDLE, counters=0.
- Accept in cycle N (in_valid & in_ready):
  - Single-cycle and illegal ops: out_valid in N+1.
  - Shift: out_valid in N+1+|k|.
  - MUL: out_valid in N+1+WIDTH.
- out_valid, result, flags and err are stable while out_ready=0. There is no new accept until out_valid & out_ready.
- Minimum throughput: one op per 2 cycles. in_ready rises the cycle after the output handshake.
- in_valid outside IDLE is ignored, and operands are not sampled.
- Reset asserted mid-SHIFT or mid-MUL returns to IDLE immediately (asynchronous). The partial result is discarded and no out_valid is produced.

## Configuration
- ALU_SEQ_MUL_EN defined: the MUL state and shift-add datapath are compiled in, with behaviour as above.
- ALU_SEQ_MUL_EN undefined: op 9 is treated as illegal (result=0, err=1, out_valid in N+1). The MUL state and multiplier registers are absent.

## Structure
- Package alu_seq_pkg holds the op code localparams, the FSM state enum (2 bits) and the flag bit index constants (C=4, L=3, F=2, Z=1, N=0).
- One sub-module, alu_seq_shifter, holds the one-bit-per-cycle shift register and counter, with load/busy/done ports. The top level owns the FSM, flags and the MUL datapath.

## Test plan
- ADD a=0x7FFF b=0x0001, accept at cycle N -> out_valid at N+1, result=0x8000, F=1, C=0, err=0.
- LSH a=0x0001 b=0x0003 -> result=0x0008 at N+4; ASH a=0x8000 b=0xFFFC (k=-4) -> result=0xF800 at N+5.
- MUL a=0x0012 b=0x0034 (WIDTH=16, macro defined) -> result=0x03A8 at N+17; macro undefined -> result=0, err=1 at N+1.
- CMP a=0x0001 b=0xFFFF -> Z=0, N=0, L=1, C/F unchanged; then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, a second in_valid is ignored.
- Illegal op 0xC -> result=0, err=1, flags unchanged; reset pulse at cycle 5 of a MUL -> out_valid stays 0, in_ready=1 after reset, next ADD completes correctly.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU controller: op codes, FSM states and PSR flag positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_ASH = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between CR16 decode, the sequential ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 16) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;
  logic             err;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result, flags, err);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result, flags, err);
endinterface

// File: rtl/alu_seq_shifter.sv
// One-bit-per-cycle shifter; amount is a signed count, positive = left, negative = right.
module alu_seq_shifter #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH):0]   amount,
  input  logic                     arith,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         data_out
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] data_reg;
  logic [SHW:0]     cnt_reg;
  logic             left_reg;
  logic             arith_reg;
  logic [SHW:0]     mag;
  logic [WIDTH-1:0] stepped;

  // Magnitude needs SHW+1 bits so that -WIDTH maps to WIDTH.
  assign mag      = amount[SHW] ? -amount : amount;
  assign stepped  = left_reg ? {data_reg[WIDTH-2:0], 1'b0}
                             : {arith_reg & data_reg[WIDTH-1], data_reg[WIDTH-1:1]};
  assign busy     = (cnt_reg != '0);
  assign done     = (cnt_reg == (SHW+1)'(1));
  assign data_out = stepped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= '0;
      cnt_reg   <= '0;
      left_reg  <= 1'b0;
      arith_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= data_in;
      cnt_reg   <= mag;
      left_reg  <= ~amount[SHW];
      arith_reg <= arith;
    end else if (busy) begin
      data_reg  <= stepped;
      cnt_reg   <= cnt_reg - (SHW+1)'(1);
    end
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle CR16 ALU controller: single-cycle ops, serial shifts, optional shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise op 9 is reported as illegal.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t           state_reg;
  logic [WIDTH-1:0] result_reg;
  logic [4:0]       flags_reg;
  logic             err_reg;
  logic             out_valid_reg;

  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic             alu_err;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [SHW:0]     amount;
  logic             accept, is_shift, start_shift;
  logic             shift_busy, shift_done;
  logic [WIDTH-1:0] shift_data;

  assign accept      = (state_reg == ST_IDLE) && bus.in_valid;
  assign amount      = bus.b[SHW:0];
  assign is_shift    = (bus.op == OP_LSH) || (bus.op == OP_ASH);
  assign start_shift = is_shift && (amount != '0);
  assign sum         = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff        = bus.a - bus.b;

  assign bus.in_ready  = (state_reg == ST_IDLE) && !reset;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.flags     = flags_reg;
  assign bus.err       = err_reg;

  always_comb begin
    alu_res   = '0;
    alu_flags = flags_reg;
    alu_err   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res           = sum[MSB:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_F] = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res           = diff;
        alu_flags[FLAG_C] = bus.a < bus.b;
        alu_flags[FLAG_F] = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_CMP: begin
        alu_res           = bus.a;
        alu_flags[FLAG_Z] = bus.a == bus.b;
        alu_flags[FLAG_N] = $signed(bus.a) < $signed(bus.b);
        alu_flags[FLAG_L] = bus.a < bus.b;
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_MOV: alu_res = bus.b;
      OP_LSH, OP_ASH: alu_res = bus.a;  // zero-amount shift completes immediately
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: alu_res = '0;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  alu_seq_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && start_shift),
    .data_in  (bus.a),
    .amount   (amount),
    .arith    (bus.op == OP_ASH),
    .busy     (shift_busy),
    .done     (shift_done),
    .data_out (shift_data)
  );

`ifdef ALU_SEQ_MUL_EN
  logic             start_mul, mul_last;
  logic [WIDTH-1:0] mcand_reg, mplier_reg, acc_reg, acc_next;
  logic [SHW:0]     mul_cnt_reg;

  assign start_mul = (bus.op == OP_MUL);
  assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_last  = (mul_cnt_reg == (SHW+1)'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      mul_cnt_reg <= '0;
    end else if (accept && start_mul) begin
      mcand_reg   <= bus.a;
      mplier_reg  <= bus.b;
      acc_reg     <= '0;
      mul_cnt_reg <= (SHW+1)'(WIDTH);
    end else if (state_reg == ST_MUL) begin
      acc_reg     <= acc_next;
      mcand_reg   <= {mcand_reg[WIDTH-2:0], 1'b0};
      mplier_reg  <= mplier_reg >> 1;
      mul_cnt_reg <= mul_cnt_reg - (SHW+1)'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      flags_reg     <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (start_shift) begin
              state_reg <= ST_SHIFT;
`ifdef ALU_SEQ_MUL_EN
            end else if (start_mul) begin
              state_reg <= ST_MUL;
`endif
            end else begin
              state_reg     <= ST_DONE;
              out_valid_reg <= 1'b1;
              result_reg    <= alu_res;
              flags_reg     <= alu_flags;
              err_reg       <= alu_err;
            end
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
            result_reg    <= shift_data;
          end else if (!shift_busy) begin
            state_reg <= ST_IDLE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (mul_last) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
            result_reg    <= acc_next;
          end
        end
`endif
        ST_DONE: begin
          if (bus.out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl (WIDTH=16): directed literal cases plus random traffic against a behavioural model.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference behaviour from the op definitions, using plain integer arithmetic.
  function automatic void ref_op(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [4:0] fin, output logic [15:0] res,
                                 output logic [4:0] fout, output logic e, output int lat);
    int s;
    int unsigned u;
    int k;
    logic [31:0] p;
    res = '0; fout = fin; e = 1'b0; lat = 0;
    k = int'(bv[4:0]);
    if (k >= 16) k = k - 32;
    case (o)
      OP_ADD: begin
        u = 32'(av) + 32'(bv);
        res = u[15:0];
        fout[FLAG_C] = (u > 32'h0000_FFFF);
        s = int'($signed(av)) + int'($signed(bv));
        fout[FLAG_F] = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        res = av - bv;
        fout[FLAG_C] = av < bv;
        s = int'($signed(av)) - int'($signed(bv));
        fout[FLAG_F] = (s > 32767) || (s < -32768);
      end
      OP_CMP: begin
        res = av;
        fout[FLAG_Z] = (av == bv);
        fout[FLAG_N] = ($signed(av) < $signed(bv));
        fout[FLAG_L] = (av < bv);
      end
      OP_AND: res = av & bv;
      OP_OR:  res = av | bv;
      OP_XOR: res = av ^ bv;
      OP_MOV: res = bv;
      OP_LSH, OP_ASH: begin
        lat = (k < 0) ? -k : k;
        if (k >= 0)          res = av << k;
        else if (o == OP_LSH) res = av >> (-k);
        else                 res = 16'($signed(av) >>> (-k));
      end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        p = 32'(av) * 32'(bv);
        res = p[15:0];
        lat = 16;
`else
        p = '0;
        e = 1'b1;
`endif
      end
      default: e = 1'b1;
    endcase
  endfunction

  // Model state: at most one operation in flight between accept and output handshake.
  int          cyc = 0;
  int          m_due = 0;
  int          n_txn = 0;
  logic        m_pending = 1'b0;
  logic [15:0] m_res = '0;
  logic [4:0]  m_flags = '0;
  logic        m_err = 1'b0;
  logic [3:0]  m_op = '0;
  logic [15:0] m_a = '0, m_b = '0;

  always @(posedge clk) begin : model
    logic [15:0] r;
    logic [4:0]  f;
    logic        e;
    int          lat;
    if (reset) begin
      m_pending <= 1'b0;
      m_flags   <= '0;
      m_err     <= 1'b0;
    end else if (!m_pending && bus.in_valid) begin
      ref_op(bus.op, bus.a, bus.b, m_flags, r, f, e, lat);
      m_pending <= 1'b1;
      m_due     <= cyc + 1 + lat;
      m_res     <= r;
      m_flags   <= f;
      m_err     <= e;
      m_op      <= bus.op;
      m_a       <= bus.a;
      m_b       <= bus.b;
      n_txn     <= n_txn + 1;
    end else if (m_pending && (cyc >= m_due) && bus.out_ready) begin
      $display("txn op=%0d a=%04h b=%04h result=%04h flags=%05b err=%0b",
               m_op, m_a, m_b, m_res, m_flags, m_err);
      m_pending <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin : compare
    logic exp_ov;
    if (reset) begin
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_flags", 32'(bus.flags), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
    end else begin
      exp_ov = m_pending && (cyc >= m_due);
      chk("in_ready", 32'(bus.in_ready), 32'(!m_pending));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("flags", 32'(bus.flags), 32'(m_flags));
      if (exp_ov) begin
        chk("result", 32'(bus.result), 32'(m_res));
        chk("err", 32'(bus.err), 32'(m_err));
      end
    end
  end

  // Issue one op, check latency/result/err/flags against literals, optionally stall the output.
  task automatic run_op(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input int exp_lat, input logic [15:0] exp_res, input logic exp_err,
                        input logic [4:0] exp_fl, input string nm, input int hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = av;
    bus.b = bv;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_res"}, 32'(bus.result), 32'(exp_res));
    chk({nm, "_err"}, 32'(bus.err), 32'(exp_err));
    chk({nm, "_flags"}, 32'(bus.flags), 32'(exp_fl));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.op = OP_ADD;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, "_hold_res"}, 32'(bus.result), 32'(exp_res));
      chk({nm, "_hold_flags"}, 32'(bus.flags), 32'(exp_fl));
      chk({nm, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int r;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    run_op(OP_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 1'b0, 5'b00100, "add_ovf", 0);
    run_op(OP_LSH, 16'h0001, 16'h0003, 4, 16'h0008, 1'b0, 5'b00100, "lsh_p3", 0);
    run_op(OP_ASH, 16'h8000, 16'hFFFC, 5, 16'hF800, 1'b0, 5'b00100, "ash_m4", 0);
`ifdef ALU_SEQ_MUL_EN
    run_op(OP_MUL, 16'h0012, 16'h0034, 17, 16'h03A8, 1'b0, 5'b00100, "mul", 0);
`else
    run_op(OP_MUL, 16'h0012, 16'h0034, 1, 16'h0000, 1'b1, 5'b00100, "mul_off", 0);
`endif
    run_op(OP_CMP, 16'h0001, 16'hFFFF, 1, 16'h0001, 1'b0, 5'b01100, "cmp_hold", 5);
    run_op(4'hC, 16'h1234, 16'h5678, 1, 16'h0000, 1'b1, 5'b01100, "illegal", 0);

    // Reset pulse in the middle of a long op.
    @(negedge clk);
    bus.in_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    bus.op = OP_MUL;
    bus.b = 16'h0034;
`else
    bus.op = OP_ASH;
    bus.b = 16'h0010;
`endif
    bus.a = 16'h0012;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (20) @(negedge clk);
    chk("midrst_no_result", 32'(bus.out_valid), 32'd0);

    run_op(OP_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b0, 5'b10000, "add_after_rst", 0);

    // Random traffic, including in_valid while busy and output back-pressure.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 19));
      bus.in_valid = 1'($urandom_range(0, 1));
      if (r < 16)      bus.op = 4'(r);
      else if (r < 18) bus.op = (r == 16) ? OP_LSH : OP_ASH;
      else             bus.op = OP_MUL;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.b = 16'h0010;
      else if ($urandom_range(0, 7) == 0) bus.b = 16'h0000;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("random_txn_count", 32'(n_txn >= 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
